// File: rtl/alu_32_bit_if.sv
// alu_32_bit_if: operand/opcode bundle and registered result/flag for the ALU
interface alu_32_bit_if;
    logic [3:0]  ALUControl;
    logic [31:0] A;
    logic [31:0] B;
    logic [31:0] ALUResult;
    logic        Zero;

    modport master (output ALUControl, A, B, input ALUResult, Zero);
    modport slave (input ALUControl, A, B, output ALUResult, Zero);
endinterface

// File: rtl/alu_32_bit.sv
// alu_32_bit: single-cycle-latency registered 32-bit ALU with zero flag
module alu_32_bit (
    input  logic          Clk,
    input  logic          Rst_n,
    alu_32_bit_if.slave   bus
);
    logic [31:0] alu_result_d, alu_result_q;
    logic        zero_d, zero_q;

    // combinational operation select; unused codes fall through to zero
    always_comb begin
        alu_result_d = 32'd0;
        case (bus.ALUControl)
            4'b0000: alu_result_d = bus.A & bus.B;
            4'b0001: alu_result_d = bus.A | bus.B;
            4'b0010: alu_result_d = bus.A + bus.B;
            4'b0011: alu_result_d = bus.A ^ bus.B;
            4'b0100: alu_result_d = bus.A * bus.B;
            4'b0110: alu_result_d = bus.A - bus.B;
            4'b0111: alu_result_d = {31'd0, $signed(bus.A) < $signed(bus.B)};
            4'b1000: alu_result_d = bus.B << bus.A[4:0];
            4'b1001: alu_result_d = bus.B >> bus.A[4:0];
            4'b1010: alu_result_d = $unsigned($signed(bus.B) >>> bus.A[4:0]);
            4'b1011: alu_result_d = {31'd0, bus.A < bus.B};
            4'b1100: alu_result_d = ~(bus.A | bus.B);
            default: alu_result_d = 32'd0;
        endcase
        zero_d = alu_result_d == 32'd0;
    end

    // result and flag captured together so they can never disagree
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            alu_result_q <= 32'd0;
            zero_q       <= 1'b1;
        end else begin
            alu_result_q <= alu_result_d;
            zero_q       <= zero_d;
        end
    end

    assign bus.ALUResult = alu_result_q;
    assign bus.Zero      = zero_q;
endmodule

// File: tb/tb_alu_32_bit.sv
// tb_alu_32_bit: randomized scoreboard bench for alu_32_bit against an arithmetic reference model
module tb_alu_32_bit;
    logic Clk;
    logic Rst_n;
    alu_32_bit_if bus ();

    alu_32_bit dut (.Clk(Clk), .Rst_n(Rst_n), .bus(bus));

    typedef struct {
        logic [3:0]  c;
        logic [31:0] r;
        logic        z;
    } exp_t;

    exp_t q[$];
    int checks = 0;
    int passed = 0;

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    function automatic logic [31:0] model(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb;
        logic [63:0] ext;
        int sh;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        sh = int'(a % 32);
        ext = {{32{b[31]}}, b};
        case (c)
            4'b0000: return a & b;
            4'b0001: return a | b;
            4'b0010: return 32'((64'(a) + 64'(b)) % 64'h1_0000_0000);
            4'b0011: return a ^ b;
            4'b0100: return 32'(sa * sb);
            4'b0110: return 32'((64'h1_0000_0000 + 64'(a) - 64'(b)) % 64'h1_0000_0000);
            4'b0111: return (sa < sb) ? 32'd1 : 32'd0;
            4'b1000: return 32'(64'(b) * (64'd1 << sh));
            4'b1001: return 32'(64'(b) / (64'd1 << sh));
            4'b1010: return ext[sh +: 32];
            4'b1011: return (64'(a) < 64'(b)) ? 32'd1 : 32'd0;
            4'b1100: return ~(a | b);
            default: return 32'd0;
        endcase
    endfunction

    task automatic check(input string name, input logic [31:0] got_r, input logic got_z, input logic [31:0] exp_r, input logic exp_z);
        checks++;
        if (got_r === exp_r && got_z === exp_z) passed++;
        else $display("FAIL %s: got result %h zero %b, expected result %h zero %b", name, got_r, got_z, exp_r, exp_z);
    endtask

    task automatic issue(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
        exp_t e;
        bus.ALUControl = c;
        bus.A = a;
        bus.B = b;
        e.c = c;
        e.r = model(c, a, b);
        e.z = (e.r == 32'd0);
        q.push_back(e);
    endtask

    task automatic op(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
        @(negedge Clk);
        issue(c, a, b);
    endtask

    always @(posedge Clk) begin
        exp_t e;
        #1;
        if (Rst_n && q.size() > 0) begin
            e = q.pop_front();
            check($sformatf("op ctrl=%b", e.c), bus.ALUResult, bus.Zero, e.r, e.z);
        end
    end

    function automatic logic [31:0] pick();
        logic [31:0] specials [6];
        specials = '{32'h0, 32'hFFFFFFFF, 32'h80000000, 32'h7FFFFFFF, 32'h1, 32'h1F};
        return ($urandom_range(0, 3) == 0) ? specials[$urandom_range(0, 5)] : $urandom;
    endfunction

    initial begin
        bus.ALUControl = 4'd0;
        bus.A = 32'd0;
        bus.B = 32'd0;
        Rst_n = 1'b1;
        #2 Rst_n = 1'b0;
        #1 check("reset_async", bus.ALUResult, bus.Zero, 32'd0, 1'b1);
        bus.ALUControl = 4'b0010;
        bus.A = 32'd5;
        bus.B = 32'd6;
        @(posedge Clk);
        #1 check("reset_held", bus.ALUResult, bus.Zero, 32'd0, 1'b1);
        @(negedge Clk);
        Rst_n = 1'b1;
        issue(4'b0010, 32'd10, 32'd7);
        op(4'b0110, 32'd10, 32'd7);
        op(4'b0000, 32'd1, 32'd3);
        op(4'b0001, 32'd1, 32'd4);
        op(4'b0000, 32'd0, 32'd0);
        op(4'b0111, 32'd10, 32'd7);
        op(4'b0111, 32'd5, 32'd7);
        op(4'b0111, 32'hFFFFFFFF, 32'd1);
        op(4'b1011, 32'hFFFFFFFF, 32'd1);
        op(4'b0111, 32'h80000000, 32'h7FFFFFFF);
        op(4'b1011, 32'h80000000, 32'h7FFFFFFF);
        op(4'b0111, 32'h1234, 32'h1234);
        op(4'b1011, 32'h1234, 32'h1234);
        op(4'b1010, 32'd4, 32'h80000000);
        op(4'b1001, 32'd4, 32'h80000000);
        op(4'b1000, 32'hFFFFFFE3, 32'h00000101);
        op(4'b1010, 32'hFFFFFFE0, 32'h80000001);
        op(4'b0010, 32'hFFFFFFFF, 32'd1);
        op(4'b0100, 32'hFFFFFFFD, 32'd7);
        op(4'b1100, 32'h0F0F0000, 32'h000000F0);
        op(4'b0011, 32'hA5A5A5A5, 32'hFFFF0000);
        op(4'b1111, 32'hFFFFFFFF, 32'hFFFFFFFF);
        op(4'b0101, 32'hFFFFFFFF, 32'h1);
        op(4'b1101, 32'h3, 32'h1);
        op(4'b1110, 32'h3, 32'h1);
        for (int i = 0; i < 400; i++) op(4'($urandom_range(0, 15)), pick(), pick());
        op(4'b0001, 32'hDEAD0000, 32'h0000BEEF);
        @(negedge Clk);
        #2 Rst_n = 1'b0;
        #1 check("reset_midop", bus.ALUResult, bus.Zero, 32'd0, 1'b1);
        bus.ALUControl = 4'b0001;
        bus.A = 32'hFFFF;
        bus.B = 32'h1;
        repeat (3) begin
            @(posedge Clk);
            #1 check("reset_hold", bus.ALUResult, bus.Zero, 32'd0, 1'b1);
        end
        @(negedge Clk);
        Rst_n = 1'b1;
        issue(4'b0010, 32'd40, 32'd2);
        op(4'b0110, 32'd9, 32'd9);
        for (int i = 0; i < 100; i++) op(4'($urandom_range(0, 15)), pick(), pick());
        repeat (4) @(negedge Clk);
        checks++;
        if (q.size() == 0) passed++;
        else $display("FAIL drain: %0d results outstanding, expected 0", q.size());
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule

// File: doc/alu_32_bit.md
ALU_32_BIT -- requirements
Module: alu_32_bit

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-002 Port: Clk  input  1  clock; all state updates on its rising edge.
REQ-003 Port: Rst_n  input  1  asynchronous active-low reset.
REQ-004 Port: ALUControl  input  4  operation select, sampled on rising Clk.
REQ-005 Port: A  input  32  operand A, sampled on rising Clk.
REQ-006 Port: B  input  32  operand B, sampled on rising Clk.
REQ-007 Port: ALUResult  output  32  registered operation result.
REQ-008 Port: Zero  output  1  registered flag; 1 iff ALUResult == 0.
REQ-009 No parameters; width fixed at 32 bits.

Function
REQ-010 Latency SHALL be exactly one cycle: operands and ALUControl present before rising edge N appear as ALUResult/Zero after edge N.
REQ-011 The block SHALL accept a new operation every cycle, with no handshake and no stall.
REQ-012 ALUControl 0000 SHALL produce A AND B.
REQ-013 ALUControl 0001 SHALL produce A OR B.
REQ-014 ALUControl 0010 SHALL produce A + B, modulo 2^32, with no carry or overflow output.
REQ-015 ALUControl 0110 SHALL produce A - B, modulo 2^32, two's complement.
REQ-016 ALUControl 0111 SHALL produce 32'd1 if signed(A) < signed(B), else 32'd0.
REQ-017 ALUControl 1011 SHALL produce 32'd1 if unsigned(A) < unsigned(B), else 32'd0.
REQ-018 ALUControl 0011 SHALL produce A XOR B.
REQ-019 ALUControl 1100 SHALL produce NOT (A OR B).
REQ-020 ALUControl 1000 SHALL produce B shifted left logical by A[4:0].
REQ-021 ALUControl 1001 SHALL produce B shifted right logical by A[4:0].
REQ-022 ALUControl 1010 SHALL produce B shifted right arithmetic by A[4:0], replicating sign bit B[31].
REQ-023 For all shifts, A[31:5] SHALL be ignored; a shift amount of 0 SHALL pass B unchanged.
REQ-024 ALUControl 0100 SHALL produce the low 32 bits of signed A * B.
REQ-025 All other ALUControl codes (0101, 1101, 1110, 1111) SHALL produce 32'd0.
REQ-026 Zero SHALL be registered in the same cycle as ALUResult and SHALL never disagree with it.
REQ-027 Signed compare boundaries SHALL hold:
- A = 0x80000000, B = 0x7FFFFFFF -> SLT = 1, SLTU = 0.
- A == B -> SLT = 0 and SLTU = 0.

Reset
REQ-028 While Rst_n = 0, regardless of Clk, ALUResult SHALL be 32'd0 and Zero SHALL be 1.
REQ-029 Assertion of Rst_n mid-operation SHALL discard the in-flight result immediately.
REQ-030 Deassertion SHALL be synchronised so that the first capture occurs on the first rising Clk with Rst_n = 1.
REQ-031 Outputs SHALL hold their reset values until that first capture.

Verification
REQ-032 Arithmetic: A=10, B=7.
- ctrl 0010 -> ALUResult 17, Zero 0.
- ctrl 0110 on the next cycle -> ALUResult 3, Zero 0.
- Each result appears one cycle after its inputs.
REQ-033 Logic:
- A=1, B=3, ctrl 0000 -> ALUResult 1, Zero 0.
- A=1, B=4, ctrl 0001 -> ALUResult 5, Zero 0.
- A=0, B=0, ctrl 0000 -> ALUResult 0, Zero 1.
REQ-034 Compare:
- A=10, B=7, ctrl 0111 -> ALUResult 0, Zero 1.
- A=5, B=7, ctrl 0111 -> ALUResult 1, Zero 0.
- A=0xFFFFFFFF, B=1: ctrl 0111 -> 1; ctrl 1011 -> 0.
REQ-035 Shifts/wrap:
- B=0x80000000, A=4, ctrl 1010 -> 0xF8000000.
- Same operands, ctrl 1001 -> 0x08000000.
- A=0xFFFFFFFF, B=1, ctrl 0010 -> ALUResult 0, Zero 1.
REQ-036 Reset:
- Drive Rst_n low between clock edges after a nonzero result.
- Outputs go to 0 / Zero=1 at once and stay there while reset is held.
- After release, the first edge captures new operands normally.
REQ-037 Undefined code: ctrl 1111 with A=B=0xFFFFFFFF -> ALUResult 0, Zero 1.
